// File: rtl/memory_turn_ctrl_if.sv
// Pick/select bus between the cursor logic, the turn controller and the
// card-pair bank. The controller takes the master side: it receives confirm
// pulses and issues select/unselect strobes. The slave side is the
// input/cursor logic and card bank, or a testbench.
interface memory_turn_ctrl_if #(
  parameter int POS_W = 4
) ();
  logic             confirm;
  logic [POS_W-1:0] cursor_pos;
  logic             new_game;
  logic [POS_W-1:0] select_pos;
  logic             select_valid;
  logic             unselect_all;

  modport master (
    input  confirm, cursor_pos, new_game,
    output select_pos, select_valid, unselect_all
  );

  modport slave (
    output confirm, cursor_pos, new_game,
    input  select_pos, select_valid, unselect_all
  );
endinterface

// File: rtl/memory_turn_ctrl.sv
// Turn controller for the memory-card game. It accepts two picks, compares
// their pair ids, and then either records the match or shows the mismatch for
// SHOW_CYCLES cycles before hiding it. It also tracks matched cards, the move
// count and the win condition.
// Optional feature: define MEM_MOVE_LIMIT_EN to end the game in LOST once
// MAX_MOVES second picks have been made.
module memory_turn_ctrl #(
  parameter int NUM_CARDS   = 16,
  parameter int POS_W       = 4,
  parameter int PAIR_W      = 3,
  parameter int SHOW_CYCLES = 50_000_000,
  parameter int MAX_MOVES   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  memory_turn_ctrl_if.master          bus,
  input  logic [NUM_CARDS*PAIR_W-1:0] pair_table,
  output logic [NUM_CARDS-1:0]        matched_mask,
  output logic [POS_W-1:0]            pairs_found,
  output logic [7:0]                  moves,
  output logic                        busy,
  output logic                        game_won,
  output logic                        game_lost
);

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_FIRST, ST_SECOND, ST_COMPARE, ST_SHOW, ST_CLEAR, ST_WON, ST_LOST
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [POS_W-1:0]     r_pos_a, w_pos_a_nxt;
  logic [POS_W-1:0]     r_pos_b, w_pos_b_nxt;
  logic [POS_W-1:0]     r_select_pos, w_select_pos_nxt;
  logic                 r_select_valid, w_select_valid_nxt;
  logic                 r_unselect_all, w_unselect_all_nxt;
  logic [NUM_CARDS-1:0] r_matched_mask, w_matched_mask_nxt;
  logic [POS_W-1:0]     r_pairs_found, w_pairs_found_nxt;
  logic [7:0]           r_moves, w_moves_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;

  logic                 w_pos_matched;
  logic                 w_pick_ok;
  logic                 w_limit_hit;
  logic [PAIR_W-1:0]    w_pair_a;
  logic [PAIR_W-1:0]    w_pair_b;

  // Pick qualification: the cursor must be on the board and its card not yet matched.
  always_comb begin
    w_pos_matched = 1'b0;
    // Loop compare instead of a direct index, so a cursor beyond NUM_CARDS
    // never indexes past the end of the mask.
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (32'(bus.cursor_pos) == i) w_pos_matched = r_matched_mask[i];
    end
    w_pick_ok = bus.confirm && (32'(bus.cursor_pos) < NUM_CARDS) && !w_pos_matched;
  end

  assign w_pair_a = pair_table[32'(r_pos_a)*PAIR_W +: PAIR_W];
  assign w_pair_b = pair_table[32'(r_pos_b)*PAIR_W +: PAIR_W];

`ifdef MEM_MOVE_LIMIT_EN
  // moves is frozen from the second pick until the turn resolves, so the limit
  // can be evaluated directly in COMPARE and CLEAR.
  assign w_limit_hit = (32'(r_moves) >= MAX_MOVES);
  assign game_lost   = (r_state == ST_LOST);
`else
  assign w_limit_hit = 1'b0;
  assign game_lost   = 1'b0;
`endif

  // Next-state and next-datapath logic for the turn sequence. new_game overrides everything.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    w_state_nxt        = r_state;
    w_pos_a_nxt        = r_pos_a;
    w_pos_b_nxt        = r_pos_b;
    w_select_pos_nxt   = r_select_pos;
    w_select_valid_nxt = 1'b0;
    w_unselect_all_nxt = 1'b0;
    w_matched_mask_nxt = r_matched_mask;
    w_pairs_found_nxt  = r_pairs_found;
    w_moves_nxt        = r_moves;
    w_cnt_nxt          = r_cnt;

    if (bus.new_game) begin
      w_state_nxt        = ST_FIRST;
      w_matched_mask_nxt = '0;
      w_pairs_found_nxt  = '0;
      w_moves_nxt        = '0;
      w_cnt_nxt          = '0;
      w_unselect_all_nxt = 1'b1;
    end else begin
      unique case (r_state)
        ST_FIRST: begin
          if (w_pick_ok) begin
            w_pos_a_nxt        = bus.cursor_pos;
            w_select_pos_nxt   = bus.cursor_pos;
            w_select_valid_nxt = 1'b1;
            w_state_nxt        = ST_SECOND;
          end
        end
        ST_SECOND: begin
          if (w_pick_ok && (bus.cursor_pos != r_pos_a)) begin
            w_pos_b_nxt        = bus.cursor_pos;
            w_select_pos_nxt   = bus.cursor_pos;
            w_select_valid_nxt = 1'b1;
            w_moves_nxt        = (r_moves == 8'hFF) ? r_moves : r_moves + 8'd1;
            w_state_nxt        = ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (w_pair_a == w_pair_b) begin
            w_matched_mask_nxt[r_pos_a] = 1'b1;
            w_matched_mask_nxt[r_pos_b] = 1'b1;
            w_pairs_found_nxt           = r_pairs_found + 1'b1;
            if (w_pairs_found_nxt == POS_W'(NUM_CARDS / 2)) w_state_nxt = ST_WON;
            else if (w_limit_hit)                           w_state_nxt = ST_LOST;
            else                                            w_state_nxt = ST_FIRST;
          end else begin
            w_cnt_nxt   = CNT_W'(SHOW_CYCLES - 1);
            w_state_nxt = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (r_cnt == '0) begin
            w_state_nxt        = ST_CLEAR;
            w_unselect_all_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        ST_CLEAR: w_state_nxt = w_limit_hit ? ST_LOST : ST_FIRST;
        ST_WON:   w_state_nxt = ST_WON;
        ST_LOST:  w_state_nxt = ST_LOST;
        default:  w_state_nxt = ST_FIRST;
      endcase
    end
  end

  // State and datapath registers; reset clears everything, including the strobes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state        <= ST_FIRST;
      r_pos_a        <= '0;
      r_pos_b        <= '0;
      r_select_pos   <= '0;
      r_select_valid <= 1'b0;
      r_unselect_all <= 1'b0;
      r_matched_mask <= '0;
      r_pairs_found  <= '0;
      r_moves        <= '0;
      r_cnt          <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pos_a        <= w_pos_a_nxt;
      r_pos_b        <= w_pos_b_nxt;
      r_select_pos   <= w_select_pos_nxt;
      r_select_valid <= w_select_valid_nxt;
      r_unselect_all <= w_unselect_all_nxt;
      r_matched_mask <= w_matched_mask_nxt;
      r_pairs_found  <= w_pairs_found_nxt;
      r_moves        <= w_moves_nxt;
      r_cnt          <= w_cnt_nxt;
    end
  end

  assign bus.select_pos   = r_select_pos;
  assign bus.select_valid = r_select_valid;
  assign bus.unselect_all = r_unselect_all;
  assign matched_mask     = r_matched_mask;
  assign pairs_found      = r_pairs_found;
  assign moves            = r_moves;
  assign busy             = (r_state == ST_COMPARE) || (r_state == ST_SHOW) || (r_state == ST_CLEAR);
  assign game_won         = (r_state == ST_WON);

endmodule

// File: doc/memory_turn_ctrl.md
# memory_turn_ctrl

Turn controller for the memory-card game: the initiator side of the per-card-pair select/unselect interface. It accepts player confirm pulses at a cursor position and issues one-cycle card-select strobes. It compares the pair identity of the two picked cards, holds mismatched cards visible for a fixed time, then broadcasts unselect-all. It also tracks matched cards, move count, and the win condition. It sits between the input/cursor logic and the bank of card-pair blocks.

## Interface
- NUM_CARDS, 16, number of card positions; must be even, ≥ 4
- POS_W, 4, width of a position index; must satisfy 2^POS_W ≥ NUM_CARDS
- PAIR_W, 3, width of a pair identifier; must satisfy 2^PAIR_W ≥ NUM_CARDS/2
- SHOW_CYCLES, 50_000_000, cycles a mismatched pair stays visible; must be ≥ 1
- MAX_MOVES, 32, move limit, used only with MEM_MOVE_LIMIT_EN
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- confirm  in  1  single-cycle pick request
- cursor_pos  in  POS_W  position picked when confirm=1
- new_game  in  1  single-cycle restart request
- pair_table  in  NUM_CARDS*PAIR_W  pair id of position i at bits [i*PAIR_W +: PAIR_W]; static during a game
- select_pos  out  POS_W  position of the latest accepted pick
- select_valid  out  1  one-cycle strobe qualifying select_pos
- unselect_all  out  1  one-cycle strobe that hides all unmatched cards
- matched_mask  out  NUM_CARDS  bit i set when position i has been matched
- pairs_found  out  POS_W  count of matched pairs
- moves  out  8  count of second picks, saturating at 255
- busy  out  1  high in COMPARE, SHOW, CLEAR
- game_won  out  1  high in WON
- game_lost  out  1  high in LOST; constant 0 without the macro

## Operation
- Reset value of every output is 0. State resets to FIRST.
- States:
  - FIRST: wait for the first pick.
  - SECOND: wait for the second pick.
  - COMPARE: compare the two picks.
  - SHOW: count down with mismatched cards visible.
  - CLEAR: issue unselect_all.
  - WON: all pairs matched.
  - LOST: move limit reached (macro only).
- A confirm is accepted only in FIRST or SECOND, and only if cursor_pos < NUM_CARDS and matched_mask[cursor_pos]=0.
  - In SECOND, the confirm is also rejected if cursor_pos equals the first pick.
  - A rejected confirm has no effect.
- FIRST, accepted confirm: store pos A, pulse select_valid with select_pos=A, go to SECOND.
- SECOND, accepted confirm: store pos B, pulse select_valid with select_pos=B, moves+1 (saturating), go to COMPARE.
- COMPARE, pair ids equal:
  - Set matched_mask[A] and matched_mask[B], increment pairs_found.
  - If the new count equals NUM_CARDS/2, go to WON; otherwise go to FIRST.
  - No unselect_all is issued.
- COMPARE, pair ids differ: load the counter with SHOW_CYCLES-1 and go to SHOW.
- SHOW: decrement the counter each cycle; at 0, go to CLEAR.
- CLEAR: unselect_all=1 for exactly this cycle, then go to FIRST.
- new_game in any state clears matched_mask, pairs_found, moves, and the counter, pulses unselect_all for one cycle, then enters FIRST. When new_game and confirm arrive in the same cycle, new_game wins.
- reset in any state, including mid-SHOW, returns to FIRST with all outputs 0 and issues no unselect_all pulse.
- select_pos holds its last value between strobes.

## Timing
- Confirm sampled at cycle N → select_valid=1 and select_pos valid at cycle N+1.
- Second confirm sampled at cycle M:
  - COMPARE occupies cycle M+1.
  - On a match, matched_mask and pairs_found update visibly at M+2.
  - On a mismatch, SHOW spans M+2 … M+1+SHOW_CYCLES, and unselect_all=1 at M+2+SHOW_CYCLES.
- Earliest accepted next confirm:
  - After a match: sampled at M+2.
  - After a mismatch: sampled at M+3+SHOW_CYCLES.
- game_won asserts at M+2 when the winning match completes.
- select_valid and unselect_all are never high in the same cycle.

## Configuration
- MEM_MOVE_LIMIT_EN defined:
  - When moves reaches MAX_MOVES at a second pick, the game still resolves that pick first.
  - A match that completes all pairs goes to WON.
  - Any other outcome goes to LOST after the normal COMPARE/SHOW/CLEAR sequence.
  - LOST asserts game_lost and ignores confirm until new_game or reset.
- MEM_MOVE_LIMIT_EN undefined: no LOST state, game_lost tied to 0, MAX_MOVES unused.

## Test plan
Setup: NUM_CARDS=4, SHOW_CYCLES=3, pair_table: pos0=0, pos1=1, pos2=0, pos3=1.
- Confirm pos0, then pos2 → two select_valid strobes (0, 2); matched_mask=0101 and pairs_found=1 two cycles after the second confirm; no unselect_all.
- Confirm pos0, then pos1 → moves=1; busy for 5 cycles; unselect_all single pulse at M+5; matched_mask unchanged.
- Confirm pos0 twice; confirm on a matched pos; confirm during SHOW → no select_valid for any of these; state unchanged.
- Match 0/2, then match 1/3 → pairs_found=2, game_won=1, later confirms ignored; new_game → unselect_all pulse, all counts 0, game_won=0.
- Assert reset mid-SHOW → next cycle all outputs 0, state FIRST, no unselect_all pulse.
- With MEM_MOVE_LIMIT_EN and MAX_MOVES=1, mismatch 0/1 → unselect_all, then game_lost=1; further confirms ignored.
